carry_serial_adder: RTL

- Slice-serial add/subtract engine built from the same MUXCY/XORCY carry-chain primitives the fabric models use: each cycle, one SLICE-bit carry chain consumes a slice of the operands and produces sum bits.
- The carry between slices is registered, so one narrow chain serves any WIDTH.
- Sits between a ready/valid operand source and a ready/valid result sink.
- Serves as the documented sequential counterpart of the combinational sum primitive.

---
 rtl/carry_chain_pkg.sv | 24 ++
 rtl/carry_slice.sv | 28 ++
 rtl/carry_serial_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/carry_chain_pkg.sv
// Shared types and sizing helpers for the slice-serial carry-chain adder.
// One package keeps the state encoding and slice sizing in a single place.
package carry_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CARRY_SLICE = 4;

  function automatic int slice_count(
    input int width,
    input int slice
  );
    return width / slice;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_slice.sv
// Combinational SLICE-bit MUXCY/XORCY carry chain.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module carry_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_p,
  input  logic             i_ci,
  output logic [SLICE-1:0] o_sum,
  output logic             o_co,
  output logic             o_c_top
);

  logic w_c;

  always_comb begin
    w_c     = i_ci;
    o_sum   = '0;
    o_c_top = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      o_sum[i] = i_p[i] ^ w_c;
      if (i == SLICE - 1) o_c_top = w_c;
      w_c = i_p[i] ? w_c : i_a[i];
    end
    o_co = w_c;
  end

endmodule

// File: rtl/carry_serial_adder.sv
// Slice-serial add/subtract engine with a registered inter-slice carry.
// Ready/valid on both sides; one operation in flight at a time.
module carry_serial_adder
  import carry_chain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = CARRY_SLICE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int N  = slice_count(WIDTH, SLICE);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_width
    $error("WIDTH must be a positive multiple of SLICE");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_co;
  logic             r_ov;

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_sum;
  logic             w_co;
  logic             w_c_top;
  logic [WIDTH-1:0] w_s_next;
  logic             w_accept;
  logic             w_last;

  assign w_p = r_a[SLICE-1:0] ^ r_b[SLICE-1:0];

  carry_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .i_a    (r_a[SLICE-1:0]),
    .i_p    (w_p),
    .i_ci   (r_c),
    .o_sum  (w_sum),
    .o_co   (w_co),
    .o_c_top(w_c_top)
  );

  // Sum slices enter at the MSB end so the final word lands aligned.
  if (N == 1) begin : g_one
    assign w_s_next = w_sum;
  end else begin : g_many
    assign w_s_next = {w_sum, r_s[WIDTH-1:SLICE]};
  end

  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == IDLE) && IN_VALID;

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (r_state)
      IDLE: begin
        IN_READY = RST_N;
        if (IN_VALID) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_co  <= 1'b0;
      r_ov  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B ^ {WIDTH{SUB}};
      r_c   <= CI ^ SUB;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_s   <= w_s_next;
      r_a   <= r_a >> SLICE;
      r_b   <= r_b >> SLICE;
      r_c   <= w_co;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_co <= w_co;
        r_ov <= w_c_top ^ w_co;
      end
    end
  end

  assign S  = r_s;
  assign CO = r_co;
  assign OV = r_ov;

endmodule
